updown_digit_counter: RTL and testbench
=======================================

UPDOWN_DIGIT_COUNTER -- requirements
Module: updown_digit_counter

Interface
REQ-001 Parameter NDIG, default 2: number of 4-bit display digits, range 1..8.
REQ-002 Parameter BCD, default 0: 0 = hex digits (0..F), 1 = decimal digits (0..9).
REQ-003 Parameter SATURATE, default 0: 0 = wrap at bounds, 1 = hold at bounds.
REQ-004 Parameter DEB_CYC, default 4: debounce stability window in clk cycles, minimum 1.
REQ-005 Parameter SCAN_DIV, default 4: clk cycles per display digit slot, minimum 2.
REQ-006 Parameter RST_VAL, default 0 (width 4*NDIG): count value after reset.
REQ-007 clk  in  1  system clock; all state on rising edge.
REQ-008 rst  in  1  reset, synchronous, active-high.
REQ-009 button  in  1  asynchronous raw push-button; one step per debounced press.
REQ-010 increment  in  1  direction: 1 = count up, 0 = count down; sampled in the step cycle.
REQ-011 load  in  1  synchronous load strobe.
REQ-012 load_val  in  4*NDIG  value written on load.
REQ-013 count  out  4*NDIG  current count; digit i occupies bits [4i+3:4i].
REQ-014 ovf  out  1  one-cycle pulse on wrap or saturation event.
REQ-015 D  out  4  digit value for the currently selected display position.
REQ-016 AN  out  NDIG  one-hot active-low digit enable, aligned with D.

Function
REQ-017 button SHALL pass a 2-flop synchroniser; the debounced level SHALL change only after the synchronised level has differed from it for DEB_CYC consecutive cycles.
REQ-018 A 0->1 transition of the debounced level SHALL produce exactly one step pulse of one clk cycle; releases produce none.
REQ-019 With button stable from a low level, count SHALL update exactly 3+DEB_CYC clk edges after the first edge sampling button high.
REQ-020 On a step with increment=1, count SHALL add 1; in BCD mode each digit above 9 SHALL reset to 0 and carry into the next digit.
REQ-021 On a step with increment=0, count SHALL subtract 1; in BCD mode a digit below 0 SHALL become 9 and borrow from the next digit.
REQ-022 MAX is all digits F (hex) or 9 (BCD); MIN is 0.
REQ-023 Wrap mode: up from MAX gives MIN, down from MIN gives MAX; ovf pulses in the same cycle count changes.
REQ-024 Saturate mode: up at MAX or down at MIN leaves count unchanged; ovf still pulses for one cycle.
REQ-025 load SHALL write load_val on the next edge and take priority over a simultaneous step, which is discarded; ovf stays 0.
REQ-026 In BCD mode any loaded digit above 9 SHALL be stored as 9.
REQ-027 The scan prescaler SHALL assert a tick every SCAN_DIV cycles; each tick advances the digit index 0,1,...,NDIG-1,0.
REQ-028 D and AN SHALL be registered and update on the tick edge: D = digit[index], AN bit index = 0, all others 1.
REQ-029 D SHALL reflect the count value at the tick edge; count changes between ticks are shown at the next slot of that digit.

Reset
REQ-030 While rst=1: count=RST_VAL, ovf=0, D=0, AN all 1, digit index=0, prescaler=0, synchroniser, debounced level and step pulse all 0.
REQ-031 rst SHALL take priority over load and step; a press in progress at reset SHALL produce no step unless it is re-detected after reset.
REQ-032 The first scan tick SHALL occur SCAN_DIV cycles after rst deasserts and SHALL select digit 0.

Structure
REQ-033 The shared package SHALL hold the DIG_W=4 constant, the BCD/HEX mode constants and the WRAP/SATURATE mode constants.
REQ-034 Synchroniser, debounce and edge detection SHALL form one sub-module, btn_debounce (parameter DEB_CYC, outputs level and step pulse).
REQ-035 Digit arithmetic SHALL be a per-digit generate loop with ripple carry/borrow; there SHALL be no clock generator and only clk SHALL be used.

Verification
REQ-036 NDIG=2, hex, wrap: load 8'hFF, one press up -> count=8'h00, single ovf pulse; one press down -> 8'hFF, ovf pulse.
REQ-037 NDIG=3, BCD: load 12'h099, press up -> 12'h100; load 12'h1A5 -> stored 12'h195.
REQ-038 SATURATE=1, BCD, NDIG=2: count 8'h99, press up -> stays 8'h99, ovf=1 for one cycle; count 0, press down -> stays 0.
REQ-039 DEB_CYC=4: glitch of 3 cycles high -> no step; clean press -> count changes exactly 7 edges after first high sample.
REQ-040 Same-cycle load and step -> count=load_val, no increment, ovf=0; rst asserted mid-debounce -> count=RST_VAL, no late step.
REQ-041 NDIG=4, SCAN_DIV=4, count 16'h1234 -> AN/D sequence 1110/4, 1101/3, 1011/2, 0111/1, each held 4 cycles, repeating.

Source files
------------

// File: rtl/updown_digit_counter_pkg.sv
// Shared constants for the up/down digit counter: digit width and the
// numeric / bound-handling mode selectors.
package updown_digit_counter_pkg;
  localparam int DIG_W = 4;

  localparam int MODE_HEX  = 0;
  localparam int MODE_BCD  = 1;
  localparam int MODE_WRAP = 0;
  localparam int MODE_SAT  = 1;

  // Decimal digits never hold a value above 9.
  function automatic logic [DIG_W-1:0] bcd_clamp(input logic [DIG_W-1:0] d);
    return (d > 4'd9) ? 4'd9 : d;
  endfunction
endpackage

// File: rtl/btn_debounce.sv
// Push-button conditioning: 2-flop synchroniser, stability-window debounce
// and a one-cycle pulse on each debounced press.
module btn_debounce #(
  parameter int DEB_CYC = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic button,
  output logic level,
  output logic step
);
  localparam int CW = (DEB_CYC > 1) ? $clog2(DEB_CYC + 1) : 1;

  logic [1:0]    sync;
  logic [CW-1:0] run;

  always_ff @(posedge clk) begin
    if (rst) begin
      sync  <= '0;
      level <= 1'b0;
      run   <= '0;
      step  <= 1'b0;
    end else begin
      sync <= {sync[0], button};
      step <= 1'b0;
      // Any cycle where the synced input agrees with the level restarts the window.
      if (sync[1] != level) begin
        if (run == CW'(DEB_CYC - 1)) begin
          level <= sync[1];
          run   <= '0;
          step  <= sync[1];
        end else begin
          run <= run + CW'(1);
        end
      end else begin
        run <= '0;
      end
    end
  end
endmodule

// File: rtl/updown_digit_counter.sv
// Button-driven up/down multi-digit counter (hex or BCD, wrap or saturate)
// with a time-multiplexed digit display output.
module updown_digit_counter
  import updown_digit_counter_pkg::*;
#(
  parameter int NDIG     = 2,
  parameter int BCD      = 0,
  parameter int SATURATE = 0,
  parameter int DEB_CYC  = 4,
  parameter int SCAN_DIV = 4,
  parameter logic [4*NDIG-1:0] RST_VAL = '0
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    button,
  input  logic                    increment,
  input  logic                    load,
  input  logic [4*NDIG-1:0]       load_val,
  output logic [4*NDIG-1:0]       count,
  output logic                    ovf,
  output logic [DIG_W-1:0]        D,
  output logic [NDIG-1:0]         AN
);
  localparam bit IS_BCD = (BCD == MODE_BCD);
  localparam bit IS_SAT = (SATURATE == MODE_SAT);
  localparam logic [DIG_W-1:0] DMAX = IS_BCD ? 4'd9 : 4'd15;
  localparam int PW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam int IW = (NDIG > 1) ? $clog2(NDIG) : 1;

  logic btn_level, step;

  btn_debounce #(.DEB_CYC(DEB_CYC)) u_deb (
    .clk    (clk),
    .rst    (rst),
    .button (button),
    .level  (btn_level),
    .step   (step)
  );

  logic [NDIG-1:0][DIG_W-1:0] digs, nxt, ld_val;
  logic [NDIG-1:0]            at_bnd;

  assign digs = count;

  for (genvar g = 0; g < NDIG; g++) begin : g_dig
    logic cin;
    assign at_bnd[g] = increment ? (digs[g] >= DMAX) : (digs[g] == '0);
    // A digit moves only when every lower digit is at its bound (carry/borrow ripple).
    if (g == 0) begin : g_lsd
      assign cin = 1'b1;
    end else begin : g_upper
      assign cin = &at_bnd[g-1:0];
    end
    always_comb begin
      nxt[g] = digs[g];
      if (cin) begin
        if (increment) nxt[g] = at_bnd[g] ? '0   : digs[g] + 4'd1;
        else           nxt[g] = at_bnd[g] ? DMAX : digs[g] - 4'd1;
      end
    end
    assign ld_val[g] = IS_BCD ? bcd_clamp(load_val[g*DIG_W +: DIG_W])
                              : load_val[g*DIG_W +: DIG_W];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      count <= RST_VAL;
      ovf   <= 1'b0;
    end else begin
      ovf <= 1'b0;
      if (load) begin
        count <= ld_val;
      end else if (step) begin
        ovf <= &at_bnd;
        if (!(IS_SAT && (&at_bnd))) count <= nxt;
      end
    end
  end

  logic [PW-1:0] pre;
  logic [IW-1:0] idx;
  logic          tick;

  assign tick = (pre == PW'(SCAN_DIV - 1));

  always_ff @(posedge clk) begin
    if (rst) begin
      pre <= '0;
      idx <= '0;
      D   <= '0;
      AN  <= '1;
    end else begin
      pre <= tick ? '0 : pre + PW'(1);
      if (tick) begin
        D   <= digs[idx];
        AN  <= ~(NDIG'(1) << idx);
        idx <= (idx == IW'(NDIG - 1)) ? '0 : idx + IW'(1);
      end
    end
  end
endmodule

// File: tb/tb_updown_digit_counter.sv
// Two configurations (hex/wrap and BCD/saturate) driven in parallel and
// compared each cycle against a value-level reference model.
module tb_updown_digit_counter;
  logic clk = 1'b0;
  logic rst = 1'b1, button = 1'b0, increment = 1'b1, load = 1'b0;
  logic [31:0] lv = '0;

  logic [7:0]  count0;  logic ovf0; logic [3:0] d0; logic [1:0] an0;
  logic [11:0] count1;  logic ovf1; logic [3:0] d1; logic [2:0] an1;

  always #5 clk = ~clk;

  updown_digit_counter #(.NDIG(2), .BCD(0), .SATURATE(0), .DEB_CYC(4), .SCAN_DIV(4),
                         .RST_VAL(8'h5A)) u0 (
    .clk(clk), .rst(rst), .button(button), .increment(increment), .load(load),
    .load_val(lv[7:0]), .count(count0), .ovf(ovf0), .D(d0), .AN(an0));

  updown_digit_counter #(.NDIG(3), .BCD(1), .SATURATE(1), .DEB_CYC(2), .SCAN_DIV(3),
                         .RST_VAL(12'h321)) u1 (
    .clk(clk), .rst(rst), .button(button), .increment(increment), .load(load),
    .load_val(lv[11:0]), .count(count1), .ovf(ovf1), .D(d1), .AN(an1));

  int cfg_nd[2]  = '{2, 3};
  int cfg_bcd[2] = '{0, 1};
  int cfg_sat[2] = '{0, 1};
  int cfg_deb[2] = '{4, 2};
  int cfg_scn[2] = '{4, 3};
  logic [31:0] cfg_rst[2] = '{32'h5A, 32'h321};

  logic [31:0] m_cnt[2], m_ovf[2], m_d[2], m_an[2];
  int sy1[2], sy2[2], lvl[2], run[2], pend[2], pre[2], idx[2];
  int ovf_seen[2];
  bit armed = 1'b0;
  int vectors = 0, miscompares = 0;

  function automatic int dec(logic [31:0] v, int nd, int base);
    int r = 0;
    for (int i = nd - 1; i >= 0; i--) r = r * base + int'((v >> (4 * i)) & 32'hF);
    return r;
  endfunction

  function automatic logic [31:0] enc(int v, int nd, int base);
    logic [31:0] r = '0;
    for (int i = 0; i < nd; i++) begin
      r = r | (32'(v % base) << (4 * i));
      v = v / base;
    end
    return r;
  endfunction

  function automatic logic [31:0] clampv(logic [31:0] v, int nd, int bcd);
    logic [31:0] r = '0;
    logic [31:0] d;
    for (int i = 0; i < nd; i++) begin
      d = (v >> (4 * i)) & 32'hF;
      if (bcd != 0 && d > 9) d = 9;
      r = r | (d << (4 * i));
    end
    return r;
  endfunction

  // Next-state of the reference for instance k, from the inputs present at this edge.
  task automatic model(input int k);
    int nd, base, v, mx, st;
    nd = cfg_nd[k];
    base = (cfg_bcd[k] != 0) ? 10 : 16;
    st = pend[k];
    pend[k] = 0;
    if (rst) begin
      armed = 1'b1;
      m_cnt[k] = cfg_rst[k]; m_ovf[k] = 0; m_d[k] = 0; m_an[k] = (1 << nd) - 1;
      sy1[k] = 0; sy2[k] = 0; lvl[k] = 0; run[k] = 0; pre[k] = 0; idx[k] = 0;
      return;
    end
    pre[k]++;
    if (pre[k] == cfg_scn[k]) begin
      pre[k] = 0;
      m_d[k] = (m_cnt[k] >> (4 * idx[k])) & 32'hF;
      m_an[k] = 32'((1 << nd) - 1) & ~(32'd1 << idx[k]);
      idx[k] = (idx[k] + 1) % nd;
    end
    m_ovf[k] = 0;
    if (load) begin
      m_cnt[k] = clampv(lv, nd, cfg_bcd[k]);
    end else if (st != 0) begin
      v = dec(m_cnt[k], nd, base);
      mx = base ** nd - 1;
      if (increment) begin
        if (v == mx) begin m_ovf[k] = 1; v = (cfg_sat[k] != 0) ? mx : 0; end
        else v = v + 1;
      end else begin
        if (v == 0) begin m_ovf[k] = 1; v = (cfg_sat[k] != 0) ? 0 : mx; end
        else v = v - 1;
      end
      m_cnt[k] = enc(v, nd, base);
    end
    if (sy2[k] != lvl[k]) begin
      run[k]++;
      if (run[k] == cfg_deb[k]) begin
        lvl[k] = sy2[k];
        run[k] = 0;
        pend[k] = lvl[k];
      end
    end else begin
      run[k] = 0;
    end
    sy2[k] = sy1[k];
    sy1[k] = int'(button);
  endtask

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  always @(posedge clk) begin
    model(0);
    model(1);
    #1;
    if (armed) begin
      chk("count0", {24'b0, count0}, m_cnt[0]);
      chk("ovf0",   {31'b0, ovf0},   m_ovf[0]);
      chk("D0",     {28'b0, d0},     m_d[0]);
      chk("AN0",    {30'b0, an0},    m_an[0]);
      chk("count1", {20'b0, count1}, m_cnt[1]);
      chk("ovf1",   {31'b0, ovf1},   m_ovf[1]);
      chk("D1",     {28'b0, d1},     m_d[1]);
      chk("AN1",    {29'b0, an1},    m_an[1]);
      if (ovf0 === 1'b1) ovf_seen[0]++;
      if (ovf1 === 1'b1) ovf_seen[1]++;
    end
  end

  task automatic do_load(input logic [31:0] v);
    @(negedge clk); lv = v; load = 1'b1;
    @(negedge clk); load = 1'b0;
  endtask

  task automatic press(input logic inc, input int hi, input int lo);
    @(negedge clk);
    ovf_seen[0] = 0; ovf_seen[1] = 0;
    increment = inc; button = 1'b1;
    repeat (hi) @(negedge clk);
    button = 1'b0;
    repeat (lo) @(negedge clk);
  endtask

  // Literal expectation checked against both the DUT and the model.
  task automatic lit2(input string nm, input logic [31:0] dut, input logic [31:0] mdl,
                      input logic [31:0] exp);
    chk({nm, "_dut"}, dut, exp);
    chk({nm, "_model"}, mdl, exp);
  endtask

  initial begin
    int lat0, lat1, r;
    rst = 1'b1;
    repeat (3) @(negedge clk);
    lit2("rst_cnt0", {24'b0, count0}, m_cnt[0], 32'h5A);
    lit2("rst_cnt1", {20'b0, count1}, m_cnt[1], 32'h321);
    chk("rst_an0", {30'b0, an0}, 32'h3);
    chk("rst_an1", {29'b0, an1}, 32'h7);
    chk("rst_d0", {28'b0, d0}, 32'h0);
    rst = 1'b0;

    do_load(32'hFFF);
    lit2("ld_ff0", {24'b0, count0}, m_cnt[0], 32'hFF);
    lit2("ld_fff1", {20'b0, count1}, m_cnt[1], 32'h999);
    press(1'b1, 8, 12);
    lit2("wrap_up0", {24'b0, count0}, m_cnt[0], 32'h00);
    lit2("sat_up1", {20'b0, count1}, m_cnt[1], 32'h999);
    chk("ovf_up0", ovf_seen[0], 1);
    chk("ovf_up1", ovf_seen[1], 1);
    press(1'b0, 8, 12);
    lit2("wrap_dn0", {24'b0, count0}, m_cnt[0], 32'hFF);
    lit2("dn1", {20'b0, count1}, m_cnt[1], 32'h998);
    chk("ovf_dn0", ovf_seen[0], 1);
    chk("ovf_dn1", ovf_seen[1], 0);

    do_load(32'h099);
    press(1'b1, 8, 12);
    lit2("inc0", {24'b0, count0}, m_cnt[0], 32'h9A);
    lit2("bcd_carry1", {20'b0, count1}, m_cnt[1], 32'h100);
    do_load(32'h1A5);
    lit2("ld_a5", {24'b0, count0}, m_cnt[0], 32'hA5);
    lit2("bcd_clamp1", {20'b0, count1}, m_cnt[1], 32'h195);

    do_load(32'h000);
    press(1'b0, 8, 12);
    lit2("wrap_min0", {24'b0, count0}, m_cnt[0], 32'hFF);
    lit2("sat_min1", {20'b0, count1}, m_cnt[1], 32'h000);
    chk("ovf_min0", ovf_seen[0], 1);
    chk("ovf_min1", ovf_seen[1], 1);

    // 3-cycle glitch is shorter than instance 0's window
    do_load(32'h042);
    press(1'b1, 3, 12);
    lit2("glitch0", {24'b0, count0}, m_cnt[0], 32'h42);

    do_load(32'h050);
    @(negedge clk); increment = 1'b1; button = 1'b1;
    lat0 = 0; lat1 = 0;
    for (int k = 1; k <= 20; k++) begin
      @(posedge clk); #1;
      if (lat0 == 0 && count0 !== 8'h50) lat0 = k;
      if (lat1 == 0 && count1 !== 12'h050) lat1 = k;
    end
    chk("latency0", lat0, 7);
    chk("latency1", lat1, 5);
    @(negedge clk); button = 1'b0;
    repeat (12) @(negedge clk);

    // load lands on the same edge as instance 0's step
    do_load(32'h0FF);
    @(negedge clk);
    ovf_seen[0] = 0; ovf_seen[1] = 0;
    increment = 1'b1; button = 1'b1;
    repeat (6) @(negedge clk);
    load = 1'b1;
    @(negedge clk); load = 1'b0; button = 1'b0;
    repeat (12) @(negedge clk);
    lit2("ld_pri0", {24'b0, count0}, m_cnt[0], 32'hFF);
    lit2("ld_pri1", {20'b0, count1}, m_cnt[1], 32'h099);
    chk("ld_pri_ovf0", ovf_seen[0], 0);
    chk("ld_pri_ovf1", ovf_seen[1], 0);

    button = 1'b1;
    repeat (3) @(negedge clk);
    rst = 1'b1; button = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    repeat (15) @(negedge clk);
    lit2("rst_mid0", {24'b0, count0}, m_cnt[0], 32'h5A);
    lit2("rst_mid1", {20'b0, count1}, m_cnt[1], 32'h321);

    // scan order after reset, loaded on the first post-reset edge
    @(negedge clk); rst = 1'b1;
    @(negedge clk); rst = 1'b0; lv = 32'h1234; load = 1'b1;
    @(negedge clk); load = 1'b0;
    repeat (3) @(posedge clk); #1;
    chk("scan0_an", {30'b0, an0}, 32'h2);
    chk("scan0_d", {28'b0, d0}, 32'h4);
    repeat (3) @(posedge clk); #1;
    chk("scan0_hold_an", {30'b0, an0}, 32'h2);
    @(posedge clk); #1;
    chk("scan1_an", {30'b0, an0}, 32'h1);
    chk("scan1_d", {28'b0, d0}, 32'h3);
    repeat (4) @(posedge clk); #1;
    chk("scan2_an", {30'b0, an0}, 32'h2);

    for (int it = 0; it < 150; it++) begin
      r = $urandom_range(0, 31);
      if (r == 0) begin
        @(negedge clk); rst = 1'b1;
        repeat ($urandom_range(1, 2)) @(negedge clk);
        rst = 1'b0;
      end else if (r < 4) begin
        do_load($urandom);
      end else begin
        press(1'($urandom_range(0, 1)), $urandom_range(1, 10), $urandom_range(1, 10));
      end
    end

    repeat (5) @(negedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
